// File: rtl/systolic_feeder_if.sv
// Host load port, start/status and systolic-array stream signals of the operand feeder.
interface systolic_feeder_if #(
  parameter int unsigned DATAWIDTH = 16,
  parameter int unsigned N_SIZE    = 5
);
  localparam int unsigned RW = $clog2(N_SIZE);
  localparam int unsigned VW = N_SIZE * DATAWIDTH;

  logic          ld_en;
  logic          ld_sel;
  logic [RW-1:0] ld_row;
  logic [VW-1:0] ld_data;
  logic          start;
  logic          busy;
  logic          done;
  logic          err;
  logic          arr_valid;
  logic [VW-1:0] arr_a;
  logic [VW-1:0] arr_b;
  logic          arr_c_valid;

  // Environment side: host loads/start plus the array's result strobe.
  modport master (
    output ld_en, ld_sel, ld_row, ld_data, start, arr_c_valid,
    input  busy, done, err, arr_valid, arr_a, arr_b
  );

  // Feeder side.
  modport slave (
    input  ld_en, ld_sel, ld_row, ld_data, start, arr_c_valid,
    output busy, done, err, arr_valid, arr_a, arr_b
  );
endinterface

// File: rtl/systolic_feeder.sv
// Operand feeder for an NxN systolic array: buffers A and B, streams column k of A with
// row k of B for k = 0..N_SIZE-1, then waits for N_SIZE result beats or a drain timeout.
module systolic_feeder #(
  parameter int unsigned DATAWIDTH     = 16,
  parameter int unsigned N_SIZE        = 5,
  parameter int unsigned DRAIN_TIMEOUT = 64
) (
  input logic              clk,
  input logic              rst_n,
  systolic_feeder_if.slave bus
);
  localparam int unsigned RW = $clog2(N_SIZE);
  localparam int unsigned CW = $clog2(N_SIZE + 1);
  localparam int unsigned TW = $clog2(DRAIN_TIMEOUT + 1);
  localparam int unsigned VW = N_SIZE * DATAWIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [RW-1:0] beat_q, beat_d;
  logic [CW-1:0] res_q, res_d;
  logic [TW-1:0] wait_q, wait_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          valid_q, valid_d;
  logic [VW-1:0] a_q, a_d;
  logic [VW-1:0] b_q, b_d;

  logic [DATAWIDTH-1:0] a_buf [N_SIZE][N_SIZE];
  logic [DATAWIDTH-1:0] b_buf [N_SIZE][N_SIZE];

  logic          wr_en;
  logic [RW-1:0] beat_n;
  logic [CW-1:0] res_inc;
  logic [TW-1:0] wait_inc;
  logic [VW-1:0] a_first, b_first, a_next, b_next;

  assign wr_en    = bus.ld_en && (state_q == IDLE) && (32'(bus.ld_row) < N_SIZE);
  assign beat_n   = beat_q + RW'(1);
  assign res_inc  = (bus.arr_c_valid && (res_q != CW'(N_SIZE))) ? res_q + CW'(1) : res_q;
  assign wait_inc = (wait_q != TW'(DRAIN_TIMEOUT)) ? wait_q + TW'(1) : wait_q;

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.arr_valid = valid_q;
  assign bus.arr_a     = a_q;
  assign bus.arr_b     = b_q;

  // Operand buffers; a row is written only while idle and only for in-range rows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < N_SIZE; r++) begin
        for (int unsigned c = 0; c < N_SIZE; c++) begin
          a_buf[RW'(r)][RW'(c)] <= '0;
          b_buf[RW'(r)][RW'(c)] <= '0;
        end
      end
    end else if (wr_en) begin
      for (int unsigned c = 0; c < N_SIZE; c++) begin
        if (bus.ld_sel) b_buf[bus.ld_row][RW'(c)] <= bus.ld_data[c*DATAWIDTH +: DATAWIDTH];
        else            a_buf[bus.ld_row][RW'(c)] <= bus.ld_data[c*DATAWIDTH +: DATAWIDTH];
      end
    end
  end

  // Beat operands: beat 0 with a same-cycle row write forwarded, and the following beat.
  always_comb begin
    a_first = '0;
    b_first = '0;
    a_next  = '0;
    b_next  = '0;
    for (int unsigned i = 0; i < N_SIZE; i++) begin
      a_first[i*DATAWIDTH +: DATAWIDTH] = a_buf[RW'(i)][RW'(0)];
      b_first[i*DATAWIDTH +: DATAWIDTH] = b_buf[RW'(0)][RW'(i)];
      if (wr_en && !bus.ld_sel && (bus.ld_row == RW'(i)))
        a_first[i*DATAWIDTH +: DATAWIDTH] = bus.ld_data[DATAWIDTH-1:0];
      if (wr_en && bus.ld_sel && (bus.ld_row == RW'(0)))
        b_first[i*DATAWIDTH +: DATAWIDTH] = bus.ld_data[i*DATAWIDTH +: DATAWIDTH];
      a_next[i*DATAWIDTH +: DATAWIDTH] = a_buf[RW'(i)][beat_n];
      b_next[i*DATAWIDTH +: DATAWIDTH] = b_buf[beat_n][RW'(i)];
    end
  end

  // Next-state and registered-output values; done beats a simultaneous timeout.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    res_d   = res_q;
    wait_d  = wait_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    valid_d = 1'b0;
    a_d     = '0;
    b_d     = '0;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (bus.start && !busy_q) begin
          state_d = STREAM;
          beat_d  = '0;
          res_d   = '0;
          wait_d  = '0;
          busy_d  = 1'b1;
          err_d   = 1'b0;
          valid_d = 1'b1;
          a_d     = a_first;
          b_d     = b_first;
        end
      end
      STREAM: begin
        res_d = res_inc;
        if (beat_q == RW'(N_SIZE - 1)) begin
          state_d = DRAIN;
        end else begin
          beat_d  = beat_n;
          valid_d = 1'b1;
          a_d     = a_next;
          b_d     = b_next;
        end
      end
      DRAIN: begin
        res_d  = res_inc;
        wait_d = wait_inc;
        if (res_inc == CW'(N_SIZE)) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (wait_inc == TW'(DRAIN_TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      res_q   <= '0;
      wait_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      res_q   <= res_d;
      wait_q  <= wait_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end
endmodule
